hash_coef_packer: RTL and testbench

//  Packs a stream of fixed-width polynomial coefficients into little-endian bytes for the Encap hash core.

---
 rtl/hash_coef_packer.sv | 97 +++++++++
 tb/tb_hash_coef_packer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_coef_packer.sv
// Packs COEF_W-bit polynomial coefficients into a little-endian byte stream for the hash core.
// One run: start pulse, up to N coefficients in, ceil(bits/8) bytes out, then a one-cycle done pulse.
module hash_coef_packer #(
    parameter int COEF_W = 11,
    parameter int N      = 757
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic              coef_last,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last
);

    localparam int ACC_W  = COEF_W + 7;
    localparam int CNT_W  = $clog2(COEF_W + 8);
    localparam int CCNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [CCNT_W-1:0]   ccnt;

    logic coef_fire;
    logic byte_fire;
    logic is_nth;

    // Handshakes and outputs derive only from registers, so byte_data/byte_last hold while stalled.
    always_comb begin
        coef_ready = (state == S_PACK) && (cnt < CNT_W'(8));
        byte_valid = ((state == S_PACK) && (cnt >= CNT_W'(8))) ||
                     ((state == S_FLUSH) && (cnt != '0));
        byte_data  = acc[7:0];
        byte_last  = (state == S_FLUSH) && (cnt <= CNT_W'(8)) && byte_valid;
        busy       = (state == S_PACK) || (state == S_FLUSH);
        done       = (state == S_DONE);
        coef_fire  = coef_valid && coef_ready;
        byte_fire  = byte_valid && byte_ready;
        is_nth     = (ccnt == CCNT_W'(N - 1));
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_PACK;
            S_PACK:  if (coef_fire && (coef_last || is_nth)) state_nx = S_FLUSH;
            S_FLUSH: if ((cnt == '0) || (byte_fire && byte_last)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ccnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                acc  <= '0;
                cnt  <= '0;
                ccnt <= '0;
                err  <= 1'b0;
            end else if (coef_fire) begin
                acc  <= acc | (ACC_W'(coef_data) << cnt);
                cnt  <= cnt + CNT_W'(COEF_W);
                ccnt <= ccnt + CCNT_W'(1);
                // Early last, or the N-th coefficient arriving without last, is a length error.
                if (coef_last != is_nth) err <= 1'b1;
            end else if (byte_fire) begin
                acc <= acc >> 8;
                cnt <= (cnt >= CNT_W'(8)) ? cnt - CNT_W'(8) : '0;
            end
        end
    end

endmodule

// File: tb/tb_hash_coef_packer.sv
// Bench for hash_coef_packer: a bit-queue reference model plus directed runs on a default and an N=2 instance.
// Every accepted byte is scored against the model; literal byte lists pin the model on the short runs.
module tb_hash_coef_packer;

    localparam int W  = 11;
    localparam int NB = 757;
    localparam int NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         coef_valid = 1'b0;
    logic         coef_last = 1'b0;
    logic         byte_ready = 1'b0;
    logic [W-1:0] coef_data = '0;
    bit           sel = 1'b0;

    logic b0_busy, b0_done, b0_err, b0_coef_ready, b0_byte_valid, b0_byte_last;
    logic b1_busy, b1_done, b1_err, b1_coef_ready, b1_byte_valid, b1_byte_last;
    logic [7:0] b0_byte_data, b1_byte_data;

    hash_coef_packer #(.COEF_W(W), .N(NB)) u_big (
        .clk(clk), .rst(rst), .start(start && !sel),
        .busy(b0_busy), .done(b0_done), .err(b0_err),
        .coef_data(coef_data), .coef_valid(coef_valid), .coef_ready(b0_coef_ready), .coef_last(coef_last),
        .byte_data(b0_byte_data), .byte_valid(b0_byte_valid), .byte_ready(byte_ready), .byte_last(b0_byte_last)
    );

    hash_coef_packer #(.COEF_W(W), .N(NS)) u_small (
        .clk(clk), .rst(rst), .start(start && sel),
        .busy(b1_busy), .done(b1_done), .err(b1_err),
        .coef_data(coef_data), .coef_valid(coef_valid), .coef_ready(b1_coef_ready), .coef_last(coef_last),
        .byte_data(b1_byte_data), .byte_valid(b1_byte_valid), .byte_ready(byte_ready), .byte_last(b1_byte_last)
    );

    logic       act_busy, act_done, act_err, act_coef_ready, act_byte_valid, act_byte_last;
    logic [7:0] act_byte_data;
    assign act_busy       = sel ? b1_busy       : b0_busy;
    assign act_done       = sel ? b1_done       : b0_done;
    assign act_err        = sel ? b1_err        : b0_err;
    assign act_coef_ready = sel ? b1_coef_ready : b0_coef_ready;
    assign act_byte_valid = sel ? b1_byte_valid : b0_byte_valid;
    assign act_byte_last  = sel ? b1_byte_last  : b0_byte_last;
    assign act_byte_data  = sel ? b1_byte_data  : b0_byte_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: lay coefficients out as a flat LSB-first bit stream, then cut into bytes.
    logic [W-1:0]  cq[$];
    byte unsigned  exp_q[$];
    byte unsigned  got_q[$];
    byte unsigned  ref_q[$];
    bit            exp_err;
    int            send_n;

    task automatic model_build(input int n, input int last_pos);
        bit bits[$];
        byte unsigned v;
        exp_q.delete();
        send_n  = (last_pos >= 0 && last_pos < n) ? last_pos + 1 : n;
        exp_err = (last_pos != n - 1);
        for (int i = 0; i < send_n; i++)
            for (int b = 0; b < W; b++) bits.push_back(cq[i][b]);
        while (bits.size() > 0) begin
            v = 8'h00;
            for (int b = 0; b < 8; b++)
                if (bits.size() > 0) v[b] = bits.pop_front();
            exp_q.push_back(v);
        end
    endtask

    int rdy_pct = 100;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            byte_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Scoreboard: every accepted byte against the model, plus hold-stable checks during stalls.
    bit         chk_en = 1'b1;
    int         done_seen = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    always @(negedge clk) begin
        if (!rst && act_done) done_seen <= done_seen + 1;
        if (rst || !chk_en) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_data_hold", act_byte_data, prev_data);
                check("stall_last_hold", act_byte_last, prev_last);
            end
            if (act_byte_valid && byte_ready) begin
                got_q.push_back(act_byte_data);
                if (exp_q.size() == 0) begin
                    check("extra_byte", 1, 0);
                end else begin
                    check("byte_data", act_byte_data, exp_q.pop_front());
                    check("byte_last", act_byte_last, exp_q.size() == 0);
                end
            end
            prev_stall <= act_byte_valid && !byte_ready;
            prev_data  <= act_byte_data;
            prev_last  <= act_byte_last;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       act_busy, 0);
        check({tag, "_done"},       act_done, 0);
        check({tag, "_err"},        act_err, 0);
        check({tag, "_coef_ready"}, act_coef_ready, 0);
        check({tag, "_byte_valid"}, act_byte_valid, 0);
        check({tag, "_byte_last"},  act_byte_last, 0);
        check({tag, "_byte_data"},  act_byte_data, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", act_busy, 1);
        check("start_err_clear", act_err, 0);
    endtask

    task automatic send_coef(input logic [W-1:0] d, input logic l, input int gap_pct);
        int t;
        while ($urandom_range(0, 99) < gap_pct) begin
            @(posedge clk);
            #1;
        end
        coef_data  = d;
        coef_last  = l;
        coef_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (act_coef_ready) break;
            t++;
            if (t > 2000) begin
                check("coef_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        coef_valid = 1'b0;
        coef_last  = 1'b0;
    endtask

    task automatic run(input bit s, input int n, input int last_pos, input int gap_pct);
        int t;
        int base;
        sel = s;
        model_build(n, last_pos);
        got_q.delete();
        base = done_seen;
        pulse_start();
        for (int i = 0; i < send_n; i++) send_coef(cq[i], (i == last_pos), gap_pct);
        t = 0;
        forever begin
            @(negedge clk);
            if (act_done) break;
            t++;
            if (t > 20000) begin
                check("done_timeout", 0, 1);
                break;
            end
        end
        check("run_err", act_err, exp_err);
        check("run_bytes_left", exp_q.size(), 0);
        check("done_busy_low", act_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_seen - base, 1);
        check("idle_byte_valid", act_byte_valid, 0);
    endtask

    byte unsigned t2_exp [3] = '{8'hFF, 8'h0F, 8'h00};
    byte unsigned t5_exp [6] = '{8'h01, 8'h10, 8'hC0, 8'h00, 8'h08, 8'h00};

    initial begin
        int diff;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // N=2 instance: 0x7FF, 0x001(last) -> FF 0F 00.
        cq = '{11'h7FF, 11'h001};
        run(1'b1, NS, 1, 0);
        check("t2_len", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) check("t2_lit", got_q[i], t2_exp[i]);

        // Early coef_last on the 4th coefficient.
        cq = '{11'h001, 11'h002, 11'h003, 11'h004};
        run(1'b0, NB, 3, 0);
        check("t5_len", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) check("t5_lit", got_q[i], t5_exp[i]);

        // Full-length run of all-ones, continuous ready.
        cq.delete();
        for (int i = 0; i < NB; i++) cq.push_back(11'h7FF);
        rdy_pct = 100;
        run(1'b0, NB, NB - 1, 0);
        check("t3_len", got_q.size(), 1041);
        if (got_q.size() == 1041) check("t3_final", got_q[1040], 8'h7F);
        ref_q = got_q;

        // Same run with random input gaps and output back-pressure.
        rdy_pct = 60;
        run(1'b0, NB, NB - 1, 30);
        check("t4_len", got_q.size(), ref_q.size());
        diff = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] != ref_q[i]) diff++;
        check("t4_seq_diff", diff, 0);

        // Full length without coef_last.
        rdy_pct = 100;
        run(1'b0, NB, -1, 0);
        check("t6_len", got_q.size(), 1041);
        check("t6_err_sticky", act_err, 1);

        // Reset mid-run: stall in FLUSH with err set, then reset for two cycles.
        chk_en  = 1'b0;
        rdy_pct = 0;
        @(posedge clk);
        #1;
        sel = 1'b0;
        pulse_start();
        send_coef(11'h7FF, 1'b1, 0);
        check("t1_pre_busy", act_busy, 1);
        check("t1_pre_err", act_err, 1);
        check("t1_pre_valid", act_byte_valid, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("t1_rst");
        rdy_pct = 100;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Clean run after reset.
        cq = '{11'h7FF, 11'h001};
        run(1'b0, NB, 1, 0);
        check("t1_post_len", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) check("t1_post_lit", got_q[i], t2_exp[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
